// File: rtl/trace_writer_if.sv
// Trace memory write port: a valid/ready word stream with an auto-incrementing address.
interface trace_writer_if #(
  parameter int ADDR_BITS       = 10,
  parameter int TRACE_DATA_BITS = 1025
);
  logic                       wr_valid;
  logic                       wr_ready;
  logic [ADDR_BITS-1:0]       wr_addr;
  logic [TRACE_DATA_BITS-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/trace_writer.sv
// Records the PIFO tree pop stream as packet/idle trace words and drains them to trace memory.
// Idle run-length encoding is enabled by defining TRACE_WRITER_IDLE_COMPRESS_EN.
module trace_writer #(
  parameter int IDLECYCLE       = 1024,
  parameter int IDLECYCLE_BITS  = $clog2(IDLECYCLE),
  parameter int PRIORITY_NUM    = 16,
  parameter int PRIORITY_BITS   = $clog2(PRIORITY_NUM),
  parameter int TREE_NUM        = 4,
  parameter int TREE_NUM_BITS   = $clog2(TREE_NUM),
  parameter int PTW             = 16,
  parameter int MTW             = TREE_NUM_BITS,
  parameter int TRACE_DATA_BITS = ((IDLECYCLE > PRIORITY_BITS + TREE_NUM_BITS + MTW + PTW) ?
                                   IDLECYCLE : (PRIORITY_BITS + TREE_NUM_BITS + MTW + PTW)) + 1,
  parameter int FIFO_SIZE       = 8,
  parameter int ADDR_BITS       = 10
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_pop_valid,
  input  logic [PRIORITY_BITS-1:0] i_pop_priority,
  input  logic [TREE_NUM_BITS-1:0] i_pop_tree_id,
  input  logic [MTW+PTW-1:0]       i_pop_data,
  input  logic                     i_flush,
  trace_writer_if.master           wr,
  output logic                     o_overflow,
  output logic                     o_flush_done
);
  localparam int DW       = MTW + PTW;
  localparam int PTR_BITS = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
  localparam int CNT_BITS = $clog2(FIFO_SIZE + 1);
  localparam logic [CNT_BITS-1:0] FIFO_DEPTH = CNT_BITS'(FIFO_SIZE);
  localparam logic [PTR_BITS-1:0] PTR_LAST   = PTR_BITS'(FIFO_SIZE - 1);

  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    return (p == PTR_LAST) ? {PTR_BITS{1'b0}} : p + PTR_BITS'(1);
  endfunction

  function automatic logic [TRACE_DATA_BITS-1:0] pkt_word(input logic [PRIORITY_BITS-1:0] pri,
                                                          input logic [TREE_NUM_BITS-1:0] tid,
                                                          input logic [DW-1:0] dat);
    logic [TRACE_DATA_BITS-1:0] w;
    w = {TRACE_DATA_BITS{1'b0}};
    w[TRACE_DATA_BITS-1] = 1'b1;
    w[DW+TREE_NUM_BITS +: PRIORITY_BITS] = pri;
    w[DW +: TREE_NUM_BITS] = tid;
    w[DW-1:0] = dat;
    return w;
  endfunction

  function automatic logic [TRACE_DATA_BITS-1:0] idle_word(input logic [IDLECYCLE_BITS-1:0] n);
    logic [TRACE_DATA_BITS-1:0] w;
    w = {TRACE_DATA_BITS{1'b0}};
    w[IDLECYCLE_BITS-1:0] = n;
    return w;
  endfunction

  logic [TRACE_DATA_BITS-1:0] mem_r [FIFO_SIZE];
  logic [PTR_BITS-1:0]        rd_ptr_r, wr_ptr_r;
  logic [CNT_BITS-1:0]        count_r, count_next_s;
  logic [ADDR_BITS-1:0]       addr_r;
  logic                       valid_r, overflow_r, flush_pending_r, flush_done_r;
  logic [TRACE_DATA_BITS-1:0] pkt_s, word0_s, word1_s;
  logic [1:0]                 need_s, wr_cnt_s;
  logic [CNT_BITS:0]          free_s;
  logic                       rd_fire_s, drop_s, flush_done_s;

  assign pkt_s = pkt_word(i_pop_priority, i_pop_tree_id, i_pop_data);

`ifdef TRACE_WRITER_IDLE_COMPRESS_EN
  localparam logic [IDLECYCLE_BITS-1:0] RUN_MAX = IDLECYCLE_BITS'(IDLECYCLE - 1);
  logic [IDLECYCLE_BITS-1:0] run_r, run_next_s, run_inc_s;

  // Event encoder: a pending idle run is always emitted ahead of the event that closes it.
  always_comb begin
    need_s     = 2'd0;
    word0_s    = pkt_s;
    word1_s    = pkt_s;
    run_inc_s  = run_r + IDLECYCLE_BITS'(1);
    run_next_s = run_r;
    if (i_pop_valid) begin
      run_next_s = {IDLECYCLE_BITS{1'b0}};
      if (run_r != {IDLECYCLE_BITS{1'b0}}) begin
        need_s  = 2'd2;
        word0_s = idle_word(run_r);
      end else begin
        need_s  = 2'd1;
      end
    end else if (i_flush) begin
      run_next_s = {IDLECYCLE_BITS{1'b0}};
      word0_s    = idle_word(run_r);
      need_s     = (run_r != {IDLECYCLE_BITS{1'b0}}) ? 2'd1 : 2'd0;
    end else if (run_inc_s == RUN_MAX) begin
      run_next_s = {IDLECYCLE_BITS{1'b0}};
      word0_s    = idle_word(RUN_MAX);
      need_s     = 2'd1;
    end else begin
      run_next_s = run_inc_s;
    end
  end

  // Idle run counter; it restarts even when the closing event is dropped.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      run_r <= {IDLECYCLE_BITS{1'b0}};
    end else begin
      run_r <= run_next_s;
    end
  end
`else
  // Event encoder without idle compression: only pops produce words.
  always_comb begin
    need_s  = i_pop_valid ? 2'd1 : 2'd0;
    word0_s = pkt_s;
    word1_s = pkt_s;
  end
`endif

  // Admission: an event is written whole or dropped whole, counting this cycle's read as free space.
  always_comb begin
    rd_fire_s    = valid_r & wr.wr_ready;
    free_s       = (CNT_BITS+1)'(FIFO_DEPTH - count_r) + (CNT_BITS+1)'(rd_fire_s);
    drop_s       = (need_s != 2'd0) && ((CNT_BITS+1)'(need_s) > free_s);
    wr_cnt_s     = drop_s ? 2'd0 : need_s;
    count_next_s = count_r + CNT_BITS'(wr_cnt_s) - CNT_BITS'(rd_fire_s);
    flush_done_s = flush_pending_r && (count_r == {CNT_BITS{1'b0}});
  end

  // Word storage; slots are only read while valid, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (wr_cnt_s != 2'd0) begin
      mem_r[wr_ptr_r] <= word0_s;
    end
    if (wr_cnt_s == 2'd2) begin
      mem_r[ptr_inc(wr_ptr_r)] <= word1_s;
    end
  end

  // Pointers, occupancy, write address and status flags.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rd_ptr_r        <= {PTR_BITS{1'b0}};
      wr_ptr_r        <= {PTR_BITS{1'b0}};
      count_r         <= {CNT_BITS{1'b0}};
      addr_r          <= {ADDR_BITS{1'b0}};
      valid_r         <= 1'b0;
      overflow_r      <= 1'b0;
      flush_pending_r <= 1'b0;
      flush_done_r    <= 1'b0;
    end else begin
      if (rd_fire_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
        addr_r   <= addr_r + ADDR_BITS'(1);
      end
      case (wr_cnt_s)
        2'd1:    wr_ptr_r <= ptr_inc(wr_ptr_r);
        2'd2:    wr_ptr_r <= ptr_inc(ptr_inc(wr_ptr_r));
        default: wr_ptr_r <= wr_ptr_r;
      endcase
      count_r         <= count_next_s;
      valid_r         <= (count_next_s != {CNT_BITS{1'b0}});
      overflow_r      <= overflow_r | drop_s;
      flush_pending_r <= i_flush | (flush_pending_r & ~flush_done_s);
      flush_done_r    <= flush_done_s;
    end
  end

  assign wr.wr_valid  = valid_r;
  assign wr.wr_addr   = addr_r;
  assign wr.wr_data   = valid_r ? mem_r[rd_ptr_r] : {TRACE_DATA_BITS{1'b0}};
  assign o_overflow   = overflow_r;
  assign o_flush_done = flush_done_r;
endmodule

// File: tb/tb_trace_writer.sv
// Scoreboard bench for trace_writer: an event-level reference model predicts trace words,
// addresses and overflow; a monitor checks every accepted memory write against it.
module tb_trace_writer;
  localparam int IDLECYCLE = 1024;
  localparam int DW        = 18;
  localparam int TID_BITS  = 2;
  localparam int TDB       = 1025;
  localparam int FIFO_SIZE = 8;
  localparam int ADDR_MOD  = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pop_valid = 1'b0;
  logic [3:0]  pop_pri = 4'd0;
  logic [1:0]  pop_tid = 2'd0;
  logic [17:0] pop_data = 18'd0;
  logic        flush = 1'b0;
  logic        ovf, fdone;

  trace_writer_if #(.ADDR_BITS(10), .TRACE_DATA_BITS(TDB)) wr_bus ();

  trace_writer dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_pop_valid(pop_valid), .i_pop_priority(pop_pri),
    .i_pop_tree_id(pop_tid), .i_pop_data(pop_data), .i_flush(flush), .wr(wr_bus),
    .o_overflow(ovf), .o_flush_done(fdone)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [TDB-1:0] exp_q[$];
  int exp_addr_q[$];
  int run_m, occ_cur, occ_next, next_addr, cyc;
  bit ovf_cur, ovf_next;
  int flush_cyc, last_valid_cyc, pulses;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [TDB-1:0] act, input logic [TDB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual msb=%0b low=%h, expected msb=%0b low=%h",
               name, act[TDB-1], act[63:0], exp[TDB-1], exp[63:0]);
    end
  endtask

  function automatic logic [TDB-1:0] pkt_w(input int p, input int t, input int d);
    return (TDB'(1) << (TDB-1)) | (TDB'(p) << (DW + TID_BITS)) | (TDB'(t) << DW) | TDB'(d);
  endfunction

  function automatic logic [TDB-1:0] idle_w(input int n);
    return TDB'(n);
  endfunction

  // Monitor: compares every accepted write and the status outputs with the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("wr_valid", TDB'(wr_bus.wr_valid), TDB'(occ_cur > 0));
      chk("overflow", TDB'(ovf), TDB'(ovf_cur));
      if (wr_bus.wr_valid) last_valid_cyc = cyc;
      if (fdone) begin
        pulses++;
        chk("flush_done_cycle", TDB'(cyc),
            TDB'(((flush_cyc > last_valid_cyc) ? flush_cyc : last_valid_cyc) + 2));
      end
      if (wr_bus.wr_valid && wr_bus.wr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: actual low=%h, expected no word", wr_bus.wr_data[63:0]);
        end else begin
          chk("wr_data", wr_bus.wr_data, exp_q.pop_front());
          chk("wr_addr", TDB'(wr_bus.wr_addr), TDB'(exp_addr_q.pop_front()));
        end
      end
    end
  end

  // Drives one cycle of stimulus, updates the model for the coming edge, then advances.
  task automatic step(input bit pv, input int p, input int t, input int d, input bit fl, input bit rdy);
    int need, free;
    bit rd;
    logic [TDB-1:0] w0, w1;
    occ_cur = occ_next;
    ovf_cur = ovf_next;
    pop_valid = pv; pop_pri = 4'(p); pop_tid = 2'(t); pop_data = 18'(d);
    flush = fl; wr_bus.wr_ready = rdy;
    if (fl) flush_cyc = cyc;
    rd = (occ_cur > 0) && rdy;
    need = 0; w0 = pkt_w(p, t, d); w1 = w0;
`ifdef TRACE_WRITER_IDLE_COMPRESS_EN
    if (pv) begin
      if (run_m > 0) begin need = 2; w0 = idle_w(run_m); end else need = 1;
      run_m = 0;
    end else if (fl) begin
      need = (run_m > 0) ? 1 : 0; w0 = idle_w(run_m); run_m = 0;
    end else begin
      run_m++;
      if (run_m == IDLECYCLE - 1) begin need = 1; w0 = idle_w(run_m); run_m = 0; end
    end
`else
    need = pv ? 1 : 0;
`endif
    free = FIFO_SIZE - occ_cur + (rd ? 1 : 0);
    if (need > free) begin
      ovf_next = 1'b1;
      need = 0;
    end else begin
      if (need >= 1) begin exp_q.push_back(w0); exp_addr_q.push_back(next_addr); next_addr = (next_addr + 1) % ADDR_MOD; end
      if (need == 2) begin exp_q.push_back(w1); exp_addr_q.push_back(next_addr); next_addr = (next_addr + 1) % ADDR_MOD; end
    end
    occ_next = occ_cur - (rd ? 1 : 0) + need;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pop_valid = 1'b0; flush = 1'b0; wr_bus.wr_ready = 1'b0;
    exp_q.delete(); exp_addr_q.delete();
    run_m = 0; occ_cur = 0; occ_next = 0; ovf_cur = 1'b0; ovf_next = 1'b0; next_addr = 0;
    pulses = 0; flush_cyc = -100; last_valid_cyc = -100;
    @(negedge clk);
    chk("rst_valid", TDB'(wr_bus.wr_valid), TDB'(0));
    chk("rst_addr", TDB'(wr_bus.wr_addr), TDB'(0));
    chk("rst_data", wr_bus.wr_data, TDB'(0));
    chk("rst_overflow", TDB'(ovf), TDB'(0));
    chk("rst_flush_done", TDB'(fdone), TDB'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((occ_next > 0 || exp_q.size() > 0) && n < 60) begin
      step(1'b0, 0, 0, 0, 1'b0, 1'b1);
      n++;
    end
    chk(name, TDB'(exp_q.size()), TDB'(0));
  endtask

  initial begin
    #2;
    // Two pops right after reset.
    do_reset();
    step(1'b1, 1, 0, 16'h0001, 1'b0, 1'b1);
    step(1'b1, 2, 1, 16'h0002, 1'b0, 1'b1);
    drain("drain_two_pops");
    chk("no_overflow", TDB'(ovf), TDB'(0));

    // Short idle run then a pop.
    do_reset();
    repeat (5) step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    step(1'b1, 3, 2, 16'hABCD, 1'b0, 1'b1);
    drain("drain_idle5");

    // Saturating idle run.
    do_reset();
    repeat (1030) step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    step(1'b1, 7, 3, 18'h2F00D, 1'b0, 1'b1);
    drain("drain_idle1030");

    // Overflow with the memory stalled.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, i, i % 4, 100 + i, 1'b0, 1'b0);
    chk("overflow_set", TDB'(ovf), TDB'(1));
    drain("drain_overflow");
    chk("overflow_sticky", TDB'(ovf), TDB'(1));

    // Flush after a short idle run.
    do_reset();
    repeat (3) step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 0, 1'b1, 1'b1);
    repeat (8) step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    chk("flush_pulse_count", TDB'(pulses), TDB'(1));
    drain("drain_flush");

    // Continuous pops through an address wrap.
    do_reset();
    for (int i = 0; i < 1100; i++)
      step(1'b1, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 262143), 1'b0, 1'b1);
    drain("drain_wrap");

    // Random traffic with back-pressure and a mid-run reset.
    do_reset();
    for (int i = 0; i < 700; i++) begin
      if (i == 350) do_reset();
      if ($urandom_range(0, 99) < 4) begin
        repeat ($urandom_range(5, 40)) step(1'b0, 0, 0, 0, 1'b0, 1'($urandom_range(0, 1)));
      end
      step($urandom_range(0, 99) < 55, $urandom_range(0, 15), $urandom_range(0, 3),
           $urandom_range(0, 262143), 1'b0, $urandom_range(0, 99) < 60);
    end
    drain("drain_random");
    chk("random_no_flush_pulse", TDB'(pulses), TDB'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
